// File: rtl/axi_lite_regfile.sv
// ---------------------------------------------------------------------------
// axi_lite_regfile
//
// AXI4-Lite slave register bank with configurable address/data width and
// register count. Registers are read/write unless their RO_MASK bit is set,
// in which case they mirror the matching hw_in slice. Writes honour byte
// strobes and raise a one-cycle wr_pulse for the register written.
// Out-of-range accesses and writes to read-only registers answer SLVERR.
// Read and write channels are independent state machines sharing the bank.
//
// Ports
//   aclk, areset          clock, synchronous active-high reset
//   aw*/w*/b*             write address / data / response channels
//   ar*/r*                read address / data channels
//   reg_out               all register contents, register i at
//                         [i*DATA_W +: DATA_W] (RO registers show hw_in)
//   hw_in                 sources for read-only registers
//   wr_pulse              one-cycle pulse per register on an accepted write
// ---------------------------------------------------------------------------
module axi_lite_regfile #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 16,
    parameter logic [NUM_REGS-1:0] RO_MASK = '0
) (
    input  logic                         aclk,
    input  logic                         areset,
    // write address channel
    input  logic [ADDR_W-1:0]            awaddr,
    input  logic                         awvalid,
    output logic                         awready,
    // write data channel
    input  logic [DATA_W-1:0]            wdata,
    input  logic [DATA_W/8-1:0]          wstrb,
    input  logic                         wvalid,
    output logic                         wready,
    // write response channel
    output logic [1:0]                   bresp,
    output logic                         bvalid,
    input  logic                         bready,
    // read address channel
    input  logic [ADDR_W-1:0]            araddr,
    input  logic                         arvalid,
    output logic                         arready,
    // read data channel
    output logic [DATA_W-1:0]            rdata,
    output logic [1:0]                   rresp,
    output logic                         rvalid,
    input  logic                         rready,
    // fabric side
    output logic [NUM_REGS*DATA_W-1:0]   reg_out,
    input  logic [NUM_REGS*DATA_W-1:0]   hw_in,
    output logic [NUM_REGS-1:0]          wr_pulse
);

    localparam int STRB_W = DATA_W / 8;
    localparam int LSB    = $clog2(STRB_W);
    localparam int IDX_W  = ADDR_W - LSB;
    localparam int RIDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {W_IDLE, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_RESP} r_state_t;

    // Word index is compared at full width so that addresses far above the
    // bank never alias onto a real register.
    function automatic logic idx_in_range(input logic [IDX_W-1:0] idx);
        return ({1'b0, idx} < (IDX_W + 1)'(NUM_REGS));
    endfunction

    // Current value of every register as seen by reads and reg_out.
    logic [DATA_W-1:0] reg_val [NUM_REGS];

    // -----------------------------------------------------------------------
    // Write channel
    // -----------------------------------------------------------------------
    w_state_t            w_state_reg;
    logic                aw_held_reg;
    logic                w_held_reg;
    logic [ADDR_W-1:0]   awaddr_reg;
    logic [DATA_W-1:0]   wdata_reg;
    logic [STRB_W-1:0]   wstrb_reg;
    logic [1:0]          bresp_reg;
    logic [NUM_REGS-1:0] wr_pulse_reg;

    logic                aw_hs;
    logic                w_hs;
    logic [ADDR_W-1:0]   w_addr_eff;
    logic [DATA_W-1:0]   w_data_eff;
    logic [STRB_W-1:0]   w_strb_eff;
    logic [IDX_W-1:0]    w_idx;
    logic [RIDX_W-1:0]   w_ridx;
    logic                w_commit;
    logic                w_ok;
    logic                wr_en;
    logic [NUM_REGS-1:0] wr_hit;

    assign awready = (w_state_reg == W_IDLE) && !aw_held_reg;
    assign wready  = (w_state_reg == W_IDLE) && !w_held_reg;
    assign bvalid  = (w_state_reg == W_RESP);
    assign bresp   = bresp_reg;

    assign aw_hs = awvalid && awready;
    assign w_hs  = wvalid && wready;

    // A held beat wins over the live bus; otherwise the beat being accepted
    // this cycle is used, so AW and W arriving together commit immediately.
    assign w_addr_eff = aw_held_reg ? awaddr_reg : awaddr;
    assign w_data_eff = w_held_reg  ? wdata_reg  : wdata;
    assign w_strb_eff = w_held_reg  ? wstrb_reg  : wstrb;

    assign w_idx  = w_addr_eff[ADDR_W-1:LSB];
    assign w_ridx = w_idx[RIDX_W-1:0];

    assign w_commit = (w_state_reg == W_IDLE)
                   && (aw_held_reg || aw_hs)
                   && (w_held_reg  || w_hs);
    assign w_ok  = idx_in_range(w_idx) && !RO_MASK[w_ridx];
    assign wr_en = w_commit && w_ok;

    always_ff @(posedge aclk) begin
        if (areset) begin
            w_state_reg <= W_IDLE;
            aw_held_reg <= 1'b0;
            w_held_reg  <= 1'b0;
            awaddr_reg  <= '0;
            wdata_reg   <= '0;
            wstrb_reg   <= '0;
            bresp_reg   <= RESP_OKAY;
        end else begin
            case (w_state_reg)
                W_IDLE: begin
                    if (w_commit) begin
                        w_state_reg <= W_RESP;
                        aw_held_reg <= 1'b0;
                        w_held_reg  <= 1'b0;
                        bresp_reg   <= w_ok ? RESP_OKAY : RESP_SLVERR;
                    end else begin
                        if (aw_hs) begin
                            aw_held_reg <= 1'b1;
                            awaddr_reg  <= awaddr;
                        end
                        if (w_hs) begin
                            w_held_reg <= 1'b1;
                            wdata_reg  <= wdata;
                            wstrb_reg  <= wstrb;
                        end
                    end
                end
                W_RESP: begin
                    if (bready) begin
                        w_state_reg <= W_IDLE;
                    end
                end
                default: w_state_reg <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            wr_pulse_reg <= '0;
        end else begin
            wr_pulse_reg <= wr_hit;
        end
    end

    assign wr_pulse = wr_pulse_reg;

    // -----------------------------------------------------------------------
    // Register bank
    // -----------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            // wr_en already excludes read-only targets.
            assign wr_hit[gi] = wr_en && (w_ridx == RIDX_W'(gi));

            if (RO_MASK[gi]) begin : g_ro
                assign reg_val[gi] = hw_in[gi*DATA_W +: DATA_W];
            end else begin : g_rw
                logic [DATA_W-1:0] store_reg;
                logic              unused_hw;

                always_ff @(posedge aclk) begin
                    if (areset) begin
                        store_reg <= '0;
                    end else if (wr_hit[gi]) begin
                        for (int b = 0; b < STRB_W; b++) begin
                            if (w_strb_eff[b]) begin
                                store_reg[b*8 +: 8] <= w_data_eff[b*8 +: 8];
                            end
                        end
                    end
                end

                assign reg_val[gi] = store_reg;
                assign unused_hw   = ^hw_in[gi*DATA_W +: DATA_W];
            end

            assign reg_out[gi*DATA_W +: DATA_W] = reg_val[gi];
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Read channel
    // -----------------------------------------------------------------------
    r_state_t          r_state_reg;
    logic [DATA_W-1:0] rdata_reg;
    logic [1:0]        rresp_reg;

    logic [IDX_W-1:0]  r_idx;
    logic [RIDX_W-1:0] r_ridx;
    logic              r_in_range;

    assign arready = (r_state_reg == R_IDLE);
    assign rvalid  = (r_state_reg == R_RESP);
    assign rdata   = rdata_reg;
    assign rresp   = rresp_reg;

    assign r_idx      = araddr[ADDR_W-1:LSB];
    assign r_ridx     = r_idx[RIDX_W-1:0];
    assign r_in_range = idx_in_range(r_idx);

    // Capturing reg_val with a non-blocking assignment on the same edge a
    // write lands means a colliding read returns the pre-write contents.
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state_reg <= R_IDLE;
            rdata_reg   <= '0;
            rresp_reg   <= RESP_OKAY;
        end else begin
            case (r_state_reg)
                R_IDLE: begin
                    if (arvalid) begin
                        r_state_reg <= R_RESP;
                        if (r_in_range) begin
                            rdata_reg <= reg_val[r_ridx];
                            rresp_reg <= RESP_OKAY;
                        end else begin
                            rdata_reg <= '0;
                            rresp_reg <= RESP_SLVERR;
                        end
                    end
                end
                R_RESP: begin
                    if (rready) begin
                        r_state_reg <= R_IDLE;
                    end
                end
                default: r_state_reg <= R_IDLE;
            endcase
        end
    end

    // Sub-word address bits carry no meaning for a word-wide register.
    logic unused_addr;
    assign unused_addr = ^{w_addr_eff[LSB-1:0], araddr[LSB-1:0]};

endmodule

// File: tb/tb_axi_lite_regfile.sv
// ---------------------------------------------------------------------------
// tb_axi_lite_regfile
//
// Directed bench for axi_lite_regfile (32-bit data, 16 registers, register 1
// read-only). Inputs are driven 1 time unit after the rising edge and outputs
// are sampled at that same point, well away from the next active edge.
// ---------------------------------------------------------------------------
module tb_axi_lite_regfile;

    localparam int ADDR_W   = 32;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 16;
    localparam logic [NUM_REGS-1:0] RO_MASK = 16'h0002;

    logic                       aclk = 1'b0;
    logic                       areset;
    logic [ADDR_W-1:0]          awaddr;
    logic                       awvalid;
    logic                       awready;
    logic [DATA_W-1:0]          wdata;
    logic [DATA_W/8-1:0]        wstrb;
    logic                       wvalid;
    logic                       wready;
    logic [1:0]                 bresp;
    logic                       bvalid;
    logic                       bready;
    logic [ADDR_W-1:0]          araddr;
    logic                       arvalid;
    logic                       arready;
    logic [DATA_W-1:0]          rdata;
    logic [1:0]                 rresp;
    logic                       rvalid;
    logic                       rready;
    logic [NUM_REGS*DATA_W-1:0] reg_out;
    logic [NUM_REGS*DATA_W-1:0] hw_in;
    logic [NUM_REGS-1:0]        wr_pulse;

    int vectors     = 0;
    int miscompares = 0;

    always #5 aclk = ~aclk;

    axi_lite_regfile #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS),
        .RO_MASK  (RO_MASK)
    ) dut (
        .aclk     (aclk),
        .areset   (areset),
        .awaddr   (awaddr),
        .awvalid  (awvalid),
        .awready  (awready),
        .wdata    (wdata),
        .wstrb    (wstrb),
        .wvalid   (wvalid),
        .wready   (wready),
        .bresp    (bresp),
        .bvalid   (bvalid),
        .bready   (bready),
        .araddr   (araddr),
        .arvalid  (arvalid),
        .arready  (arready),
        .rdata    (rdata),
        .rresp    (rresp),
        .rvalid   (rvalid),
        .rready   (rready),
        .reg_out  (reg_out),
        .hw_in    (hw_in),
        .wr_pulse (wr_pulse)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    // Single write with AW and W presented together; checks the response and
    // the wr_pulse in the cycle after commit, then that the pulse is gone.
    task automatic axi_write(input string tag, input logic [31:0] addr,
                             input logic [31:0] data, input logic [3:0] strb,
                             input logic [1:0] exp_resp, input logic [15:0] exp_pulse);
        int cycles = 0;
        awaddr  = addr;
        awvalid = 1'b1;
        wdata   = data;
        wstrb   = strb;
        wvalid  = 1'b1;
        while (!(awready && wready) && cycles < 20) begin
            tick();
            cycles++;
        end
        check({tag, "_ready"}, {62'd0, awready, wready}, 64'd3);
        tick();
        awvalid = 1'b0;
        wvalid  = 1'b0;
        check({tag, "_bvalid"}, 64'(bvalid), 64'd1);
        check({tag, "_bresp"}, 64'(bresp), 64'(exp_resp));
        check({tag, "_pulse"}, 64'(wr_pulse), 64'(exp_pulse));
        $display("write %s addr=%h data=%h strb=%b bresp=%b pulse=%h",
                 tag, addr, data, strb, bresp, wr_pulse);
        bready = 1'b1;
        tick();
        bready = 1'b0;
        check({tag, "_pulse_gone"}, 64'(wr_pulse), 64'd0);
        check({tag, "_bvalid_gone"}, 64'(bvalid), 64'd0);
    endtask

    task automatic axi_read(input string tag, input logic [31:0] addr,
                            input logic [31:0] exp_data, input logic [1:0] exp_resp);
        int cycles = 0;
        araddr  = addr;
        arvalid = 1'b1;
        while (!arready && cycles < 20) begin
            tick();
            cycles++;
        end
        check({tag, "_arready"}, 64'(arready), 64'd1);
        tick();
        arvalid = 1'b0;
        check({tag, "_rvalid"}, 64'(rvalid), 64'd1);
        check({tag, "_rdata"}, 64'(rdata), 64'(exp_data));
        check({tag, "_rresp"}, 64'(rresp), 64'(exp_resp));
        $display("read  %s addr=%h rdata=%h rresp=%b", tag, addr, rdata, rresp);
        rready = 1'b1;
        tick();
        rready = 1'b0;
        check({tag, "_rvalid_gone"}, 64'(rvalid), 64'd0);
    endtask

    initial begin
        areset  = 1'b1;
        awaddr  = '0;
        awvalid = 1'b0;
        wdata   = '0;
        wstrb   = '0;
        wvalid  = 1'b0;
        bready  = 1'b0;
        araddr  = '0;
        arvalid = 1'b0;
        rready  = 1'b0;
        hw_in   = '0;
        hw_in[1*DATA_W +: DATA_W] = 32'hCAFE0001;

        // ---- reset state ----
        repeat (2) @(posedge aclk);
        #1;
        areset = 1'b0;
        check("rst_awready", 64'(awready), 64'd1);
        check("rst_wready",  64'(wready),  64'd1);
        check("rst_arready", 64'(arready), 64'd1);
        check("rst_bvalid",  64'(bvalid),  64'd0);
        check("rst_rvalid",  64'(rvalid),  64'd0);
        check("rst_bresp",   64'(bresp),   64'd0);
        check("rst_rresp",   64'(rresp),   64'd0);
        check("rst_rdata",   64'(rdata),   64'd0);
        check("rst_pulse",   64'(wr_pulse), 64'd0);
        $display("reset released");

        // ---- read after reset ----
        axi_read("rd_idx3", 32'h0C, 32'h0, 2'b00);

        // ---- byte-strobe write ----
        axi_write("wr_full2", 32'h08, 32'h11223344, 4'b1111, 2'b00, 16'h0004);
        axi_write("wr_strb2", 32'h08, 32'hDEADBEEF, 4'b0101, 2'b00, 16'h0004);
        axi_read("rd_strb2", 32'h08, 32'h11AD33EF, 2'b00);
        check("regout2", 64'(reg_out[2*DATA_W +: DATA_W]), 64'h11AD33EF);

        // ---- wstrb = 0: OKAY, unchanged, pulse still fires ----
        axi_write("wr_strb0", 32'h08, 32'hFFFFFFFF, 4'b0000, 2'b00, 16'h0004);
        check("regout2_keep", 64'(reg_out[2*DATA_W +: DATA_W]), 64'h11AD33EF);

        // ---- AW at cycle 0, W at cycle 3, B back-pressured 5 cycles ----
        tick();
        awaddr  = 32'h10;
        awvalid = 1'b1;                        // cycle 0
        tick();
        awvalid = 1'b0;                        // cycle 1
        check("split_c1_awready", 64'(awready), 64'd0);
        check("split_c1_wready",  64'(wready),  64'd1);
        check("split_c1_bvalid",  64'(bvalid),  64'd0);
        tick();                                // cycle 2
        check("split_c2_awready", 64'(awready), 64'd0);
        tick();                                // cycle 3
        check("split_c3_awready", 64'(awready), 64'd0);
        wdata  = 32'hA5A50003;
        wstrb  = 4'b1111;
        wvalid = 1'b1;
        tick();                                // cycle 4
        wvalid = 1'b0;
        check("split_c4_bvalid", 64'(bvalid), 64'd1);
        check("split_c4_bresp",  64'(bresp),  64'd0);
        check("split_c4_pulse",  64'(wr_pulse), 64'h0010);
        $display("write split addr=10 data=a5a50003 bresp=%b", bresp);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_bvalid",  64'(bvalid),  64'd1);
            check("bp_bresp",   64'(bresp),   64'd0);
            check("bp_awready", 64'(awready), 64'd0);
            check("bp_pulse",   64'(wr_pulse), 64'd0);
        end
        bready = 1'b1;
        tick();
        bready = 1'b0;
        check("bp_done_bvalid",  64'(bvalid),  64'd0);
        check("bp_done_awready", 64'(awready), 64'd1);
        axi_read("rd_split", 32'h10, 32'hA5A50003, 2'b00);

        // ---- read back-pressure: rdata stable ----
        araddr  = 32'h08;
        arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rbp_rvalid",  64'(rvalid),  64'd1);
            check("rbp_rdata",   64'(rdata),   64'h11AD33EF);
            check("rbp_arready", 64'(arready), 64'd0);
        end
        rready = 1'b1;
        tick();
        rready = 1'b0;
        check("rbp_done", 64'(rvalid), 64'd0);

        // ---- out of range ----
        axi_write("wr_oor", 32'h40, 32'h12345678, 4'b1111, 2'b10, 16'h0000);
        axi_read("rd_oor", 32'h40, 32'h0, 2'b10);

        // ---- read-only register ----
        axi_read("rd_ro", 32'h04, 32'hCAFE0001, 2'b00);
        axi_write("wr_ro", 32'h04, 32'h12345678, 4'b1111, 2'b10, 16'h0000);
        check("regout_ro", 64'(reg_out[1*DATA_W +: DATA_W]), 64'hCAFE0001);
        hw_in[1*DATA_W +: DATA_W] = 32'hCAFE0002;
        #1;
        check("regout_ro_live", 64'(reg_out[1*DATA_W +: DATA_W]), 64'hCAFE0002);
        axi_read("rd_ro2", 32'h04, 32'hCAFE0002, 2'b00);

        // ---- read/write collision on index 0 ----
        axi_write("wr_idx0", 32'h00, 32'h00000009, 4'b1111, 2'b00, 16'h0001);
        awaddr  = 32'h00;
        awvalid = 1'b1;
        wdata   = 32'h00000005;
        wstrb   = 4'b1111;
        wvalid  = 1'b1;
        araddr  = 32'h00;
        arvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        wvalid  = 1'b0;
        arvalid = 1'b0;
        check("coll_rvalid", 64'(rvalid), 64'd1);
        check("coll_rdata",  64'(rdata),  64'h9);
        check("coll_bvalid", 64'(bvalid), 64'd1);
        $display("collision rdata=%h bresp=%b", rdata, bresp);
        bready = 1'b1;
        rready = 1'b1;
        tick();
        bready = 1'b0;
        rready = 1'b0;
        axi_read("rd_idx0", 32'h00, 32'h5, 2'b00);

        // ---- reset during W_RESP ----
        awaddr  = 32'h14;
        awvalid = 1'b1;
        wdata   = 32'h00000077;
        wstrb   = 4'b1111;
        wvalid  = 1'b1;
        tick();
        awvalid = 1'b0;
        wvalid  = 1'b0;
        check("rstmid_bvalid_pre", 64'(bvalid), 64'd1);
        check("rstmid_reg5_pre", 64'(reg_out[5*DATA_W +: DATA_W]), 64'h77);
        areset = 1'b1;
        tick();
        areset = 1'b0;
        check("rstmid_bvalid",  64'(bvalid),  64'd0);
        check("rstmid_awready", 64'(awready), 64'd1);
        check("rstmid_reg5",    64'(reg_out[5*DATA_W +: DATA_W]), 64'h0);
        $display("reset during W_RESP bvalid=%b awready=%b", bvalid, awready);

        // ---- reset discards a buffered AW ----
        awaddr  = 32'h18;
        awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        check("held_awready", 64'(awready), 64'd0);
        areset = 1'b1;
        tick();
        areset = 1'b0;
        check("held_cleared", 64'(awready), 64'd1);
        wdata  = 32'h0000ABCD;
        wstrb  = 4'b1111;
        wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        tick();
        check("held_no_bvalid", 64'(bvalid), 64'd0);
        check("held_no_write", 64'(reg_out[6*DATA_W +: DATA_W]), 64'h0);
        $display("buffered AW discarded by reset");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
